// File: rtl/store_retire_buffer.sv
// store_retire_buffer
//
// Retire-side write-combining store buffer. Retiring stores from the ROB are
// captured into a small circular array of word entries, merged with an
// existing entry for the same word where possible, and drained one at a time
// to data memory. store_executed tells the ROB that the store has been
// buffered. A combinational lookup lets the load/store issue unit forward
// buffered store data to loads.
//
// Handshakes:
//   The memory port is valid/ready. mem_wr_en is valid, and mem_ready is ready.
//   mem_addr and mem_wdata are held stable while mem_wr_en=1. The write is
//   complete on the rising edge where mem_wr_en=1 and mem_ready=1.
//   The retire side is request/acknowledge. A store is requested while
//   ret_valid=1 and ret_store_ready=1. It is accepted on the rising edge where
//   it combines or allocates. store_executed pulses for one cycle after that
//   edge, and no new request is taken during the pulse.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ret_valid           retire bus valid
//   ret_store_ready     retiring instruction is a store with addr/data ready
//   ret_mem_address     store byte address (word aligned, bits [1:0] ignored)
//   ret_rs2_data        store data
//   ret_flush           ROB flush (does not affect buffered stores)
//   store_executed      one-cycle pulse, the previous cycle's store was accepted
//   mem_wr_en           memory write request valid
//   mem_addr, mem_wdata head entry address/data while mem_wr_en=1, else 0
//   mem_ready           memory accepts the write this cycle
//   ld_addr             forwarding lookup address
//   ld_hit, ld_data     forwarding result (ld_data=0 when no hit)
//   buf_full, buf_empty derived from the registered entry count
//   dbg_state           drain FSM state (0=IDLE, 1=WRITE)

module store_retire_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ret_valid,
    input  logic          ret_store_ready,
    input  logic [AW-1:0] ret_mem_address,
    input  logic [31:0]   ret_rs2_data,
    input  logic          ret_flush,
    output logic          store_executed,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ready,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hit,
    output logic [31:0]   ld_data,
    output logic          buf_full,
    output logic          buf_empty,
    output logic          dbg_state
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } drain_state_t;

    logic [31:0]      wc_data  [DEPTH];
    logic [AW-1:0]    wc_addr  [DEPTH];
    logic [DEPTH-1:0] wc_valid;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW:0]      count;

    drain_state_t state;
    drain_state_t state_next;

    logic          req;
    logic          comb_hit;
    logic [PW-1:0] comb_idx;
    logic          do_combine;
    logic          do_alloc;
    logic          accept;
    logic          drain_done;
    logic          young_found;

    // The flush and the byte-offset bits have no effect on the buffer.
    logic unused_inputs;
    assign unused_inputs = ^{ret_flush, ret_mem_address[1:0], ld_addr[1:0]};

    // Holding off the request during the pulse stops the same ROB head from
    // being captured twice while the ROB pops it.
    assign req = ret_valid & ret_store_ready & ~store_executed;

    // Combine candidate. The head is excluded while it is being written. Its
    // data is already on the memory bus, so a new store to that word must
    // get a fresh entry.
    always_comb begin
        comb_hit = 1'b0;
        comb_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wc_valid[i] &&
                (wc_addr[i][AW-1:2] == ret_mem_address[AW-1:2]) &&
                !((state == ST_WRITE) && (PW'(i) == head))) begin
                comb_hit = 1'b1;
                comb_idx = PW'(i);
            end
        end
    end

    assign do_combine = req & comb_hit;
    assign do_alloc   = req & ~comb_hit & (count != (PW+1)'(DEPTH));
    assign accept     = do_combine | do_alloc;
    assign drain_done = (state == ST_WRITE) & mem_ready;

    // Drain FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (count != '0) state_next = ST_WRITE;
            ST_WRITE: if (mem_ready)   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Entry storage, pointers and count. While writing, count >= 1. An
    // allocation needs count < DEPTH, so tail never equals head when both
    // an allocate and a drain complete in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                wc_data[i] <= '0;
                wc_addr[i] <= '0;
            end
            wc_valid       <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            store_executed <= 1'b0;
        end else begin
            store_executed <= accept;
            if (do_combine) begin
                wc_data[comb_idx] <= ret_rs2_data;
            end
            if (drain_done) begin
                wc_valid[head] <= 1'b0;
                head           <= head + PW'(1);
            end
            if (do_alloc) begin
                wc_data[tail]  <= ret_rs2_data;
                wc_addr[tail]  <= {ret_mem_address[AW-1:2], 2'b00};
                wc_valid[tail] <= 1'b1;
                tail           <= tail + PW'(1);
            end
            count <= count + (PW+1)'(do_alloc) - (PW+1)'(drain_done);
        end
    end

    // Forwarding. A word can have two entries only when a store hit the head
    // while it was being written. The other entry is the younger one, so it
    // takes priority over the head.
    always_comb begin
        ld_hit      = 1'b0;
        ld_data     = '0;
        young_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wc_valid[i] && (wc_addr[i][AW-1:2] == ld_addr[AW-1:2])) begin
                ld_hit = 1'b1;
                if ((state == ST_WRITE) && (PW'(i) == head)) begin
                    if (!young_found) ld_data = wc_data[i];
                end else begin
                    ld_data     = wc_data[i];
                    young_found = 1'b1;
                end
            end
        end
    end

    assign mem_wr_en = (state == ST_WRITE);
    assign mem_addr  = mem_wr_en ? wc_addr[head] : '0;
    assign mem_wdata = mem_wr_en ? wc_data[head] : '0;
    assign buf_full  = (count == (PW+1)'(DEPTH));
    assign buf_empty = (count == '0);
    assign dbg_state = state;

endmodule

// File: tb/tb_store_retire_buffer.sv
module tb_store_retire_buffer;

  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ret_valid, ret_store_ready, ret_flush, mem_ready;
  logic [31:0] ret_mem_address, ret_rs2_data, ld_addr;
  logic        store_executed, mem_wr_en, ld_hit, buf_full, buf_empty, dbg_state;
  logic [31:0] mem_addr, mem_wdata, ld_data;

  store_retire_buffer #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .ret_valid(ret_valid), .ret_store_ready(ret_store_ready),
    .ret_mem_address(ret_mem_address), .ret_rs2_data(ret_rs2_data),
    .ret_flush(ret_flush), .store_executed(store_executed),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .ld_addr(ld_addr), .ld_hit(ld_hit),
    .ld_data(ld_data), .buf_full(buf_full), .buf_empty(buf_empty),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard: expected memory writes {addr, data}
  logic [63:0] exp_q[$];

  // reference model: entries oldest first
  logic [31:0] m_qa[$];
  logic [31:0] m_qd[$];
  bit          m_wr    = 1'b0;
  bit          m_pulse = 1'b0;
  int          m_acc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_qa.delete();
    m_qd.delete();
    exp_q.delete();
    m_wr    = 1'b0;
    m_pulse = 1'b0;
  endtask

  // Compare all DUT outputs to the model, then advance the model by one edge
  // using the inputs currently driven, and score any memory write.
  task automatic sample_and_model();
    logic        e_hit;
    logic [31:0] e_ld;
    logic [63:0] w;
    int          sz;
    int          found;
    bit          acc;
    bit          done;
    bit          req;
    int          lo;
    e_hit = 1'b0;
    e_ld  = '0;
    for (int i = m_qa.size() - 1; i >= 0; i--) begin
      if (m_qa[i][31:2] == ld_addr[31:2]) begin
        e_hit = 1'b1;
        e_ld  = m_qd[i];
        break;
      end
    end
    chk("store_executed", 32'(store_executed), 32'(m_pulse));
    chk("mem_wr_en", 32'(mem_wr_en), 32'(m_wr));
    chk("dbg_state", 32'(dbg_state), 32'(m_wr));
    chk("mem_addr", mem_addr, m_wr ? m_qa[0] : 32'h0);
    chk("mem_wdata", mem_wdata, m_wr ? m_qd[0] : 32'h0);
    chk("buf_full", 32'(buf_full), 32'(m_qa.size() == DEPTH));
    chk("buf_empty", 32'(buf_empty), 32'(m_qa.size() == 0));
    chk("ld_hit", 32'(ld_hit), 32'(e_hit));
    chk("ld_data", ld_data, e_ld);

    if (rst) begin
      model_reset();
      return;
    end

    sz   = m_qa.size();
    req  = ret_valid && ret_store_ready && !m_pulse;
    acc  = 1'b0;
    done = m_wr && mem_ready;
    if (req) begin
      found = -1;
      lo    = m_wr ? 1 : 0;
      for (int i = sz - 1; i >= lo; i--) begin
        if (m_qa[i][31:2] == ret_mem_address[31:2]) begin
          found = i;
          break;
        end
      end
      if (found >= 0) begin
        m_qd[found] = ret_rs2_data;
        acc = 1'b1;
      end else if (sz < DEPTH) begin
        m_qa.push_back({ret_mem_address[31:2], 2'b00});
        m_qd.push_back(ret_rs2_data);
        acc = 1'b1;
      end
    end
    if (done) begin
      exp_q.push_back({m_qa[0], m_qd[0]});
      void'(m_qa.pop_front());
      void'(m_qd.pop_front());
    end
    m_wr    = m_wr ? !mem_ready : (sz != 0);
    m_pulse = acc;
    if (acc) m_acc++;

    if (mem_wr_en && mem_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got write %h/%h expected no write", mem_addr, mem_wdata);
      end else begin
        w = exp_q.pop_front();
        chk("wr_addr", mem_addr, w[63:32]);
        chk("wr_data", mem_wdata, w[31:0]);
      end
    end
  endtask

  // driver
  task automatic drive_in(input logic rv, input logic rsr, input logic [31:0] a,
                          input logic [31:0] d, input logic mr, input logic fl,
                          input logic [31:0] la, input logic r);
    ret_valid       = rv;
    ret_store_ready = rsr;
    ret_mem_address = a;
    ret_rs2_data    = d;
    mem_ready       = mr;
    ret_flush       = fl;
    ld_addr         = la;
    rst             = r;
  endtask

  task automatic step(input logic rv, input logic [31:0] a, input logic [31:0] d,
                      input logic mr, input logic fl, input logic [31:0] la,
                      input logic r);
    drive_in(rv, rv, a, d, mr, fl, la, r);
    @(negedge clk);
    sample_and_model();
    @(posedge clk);
    #1;
  endtask

  // directed vectors
  typedef struct {
    logic        rv;
    logic [31:0] a;
    logic [31:0] d;
    logic        mr;
    logic [31:0] la;
    logic        e_se;
    logic        e_wr;
    logic [31:0] e_ma;
    logic [31:0] e_wd;
    logic        e_hit;
    logic [31:0] e_ld;
    logic        e_full;
    logic        e_empty;
  } vec_t;

  function automatic vec_t mk(logic rv, logic [31:0] a, logic [31:0] d, logic mr,
                              logic [31:0] la, logic se, logic wr, logic [31:0] ma,
                              logic [31:0] wd, logic hit, logic [31:0] ld,
                              logic full, logic empty);
    vec_t v;
    v.rv = rv; v.a = a; v.d = d; v.mr = mr; v.la = la;
    v.e_se = se; v.e_wr = wr; v.e_ma = ma; v.e_wd = wd;
    v.e_hit = hit; v.e_ld = ld; v.e_full = full; v.e_empty = empty;
    return v;
  endfunction

  vec_t vecs[14];
  logic [31:0] full_addr[5];

  initial begin
    int idx;
    int base;
    logic [31:0] ra;

    // single store, then a combine behind a head held in WRITE
    vecs[0]  = mk(1, 32'h100, 32'hDEADBEEF, 1, 32'h100, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0, 1);
    vecs[1]  = mk(0, 32'h0,   32'h0,        1, 32'h100, 1, 0, 32'h0,   32'h0,        1, 32'hDEADBEEF, 0, 0);
    vecs[2]  = mk(0, 32'h0,   32'h0,        1, 32'h100, 0, 1, 32'h100, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0);
    vecs[3]  = mk(0, 32'h0,   32'h0,        0, 32'h200, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0, 1);
    vecs[4]  = mk(1, 32'h1F0, 32'hAA,       0, 32'h200, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0, 1);
    vecs[5]  = mk(1, 32'h1F0, 32'hAA,       0, 32'h200, 1, 0, 32'h0,   32'h0,        0, 32'h0,        0, 0);
    vecs[6]  = mk(1, 32'h200, 32'h11,       0, 32'h200, 0, 1, 32'h1F0, 32'hAA,       0, 32'h0,        0, 0);
    vecs[7]  = mk(1, 32'h200, 32'h22,       0, 32'h200, 1, 1, 32'h1F0, 32'hAA,       1, 32'h11,       0, 0);
    vecs[8]  = mk(1, 32'h200, 32'h22,       0, 32'h200, 0, 1, 32'h1F0, 32'hAA,       1, 32'h11,       0, 0);
    vecs[9]  = mk(0, 32'h0,   32'h0,        0, 32'h200, 1, 1, 32'h1F0, 32'hAA,       1, 32'h22,       0, 0);
    vecs[10] = mk(0, 32'h0,   32'h0,        1, 32'h200, 0, 1, 32'h1F0, 32'hAA,       1, 32'h22,       0, 0);
    vecs[11] = mk(0, 32'h0,   32'h0,        1, 32'h200, 0, 0, 32'h0,   32'h0,        1, 32'h22,       0, 0);
    vecs[12] = mk(0, 32'h0,   32'h0,        1, 32'h200, 0, 1, 32'h200, 32'h22,       1, 32'h22,       0, 0);
    vecs[13] = mk(0, 32'h0,   32'h0,        0, 32'h200, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0, 1);

    full_addr[0] = 32'h0;
    full_addr[1] = 32'h4;
    full_addr[2] = 32'h8;
    full_addr[3] = 32'hC;
    full_addr[4] = 32'h10;

    // reset
    drive_in(0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0, 1);
    model_reset();

    // table-driven directed vectors
    for (int i = 0; i < 14; i++) begin
      drive_in(vecs[i].rv, vecs[i].rv, vecs[i].a, vecs[i].d, vecs[i].mr, 0, vecs[i].la, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_se", i), 32'(store_executed), 32'(vecs[i].e_se));
      chk($sformatf("vec%0d_wr", i), 32'(mem_wr_en), 32'(vecs[i].e_wr));
      chk($sformatf("vec%0d_maddr", i), mem_addr, vecs[i].e_ma);
      chk($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].e_wd);
      chk($sformatf("vec%0d_hit", i), 32'(ld_hit), 32'(vecs[i].e_hit));
      chk($sformatf("vec%0d_ld", i), ld_data, vecs[i].e_ld);
      chk($sformatf("vec%0d_full", i), 32'(buf_full), 32'(vecs[i].e_full));
      chk($sformatf("vec%0d_empty", i), 32'(buf_empty), 32'(vecs[i].e_empty));
      sample_and_model();
      @(posedge clk);
      #1;
    end

    // full backpressure: five stores, memory stalled
    base = m_acc;
    for (int c = 0; c < 14; c++) begin
      idx = m_acc - base;
      step(idx < 5, full_addr[idx < 5 ? idx : 0], 32'hA0 + 32'(idx), 0, 0, 32'h8, 0);
    end
    chk("full_set", 32'(buf_full), 32'h1);
    chk("full_accepts", 32'(m_acc - base), 32'd4);
    step(1, full_addr[4], 32'hA4, 1, 0, 32'h10, 0);
    chk("full_freed_se", 32'(store_executed), 32'h0);
    chk("full_freed_full", 32'(buf_full), 32'h0);
    step(1, full_addr[4], 32'hA4, 0, 0, 32'h10, 0);
    chk("fifth_se", 32'(store_executed), 32'h1);
    chk("fifth_full", 32'(buf_full), 32'h1);
    chk("fifth_fwd", ld_data, 32'hA4);
    for (int c = 0; c < 12; c++) step(0, 0, 0, 1, 0, 32'h10, 0);
    chk("full_drained", 32'(buf_empty), 32'h1);

    // head in WRITE is not combined
    step(1, 32'h300, 32'h1, 0, 0, 32'h300, 0);
    step(0, 0, 0, 0, 0, 32'h300, 0);
    chk("hw_writing", 32'(mem_wr_en), 32'h1);
    step(1, 32'h300, 32'h5, 0, 0, 32'h300, 0);
    step(0, 0, 0, 0, 0, 32'h300, 0);
    chk("hw_empty", 32'(buf_empty), 32'h0);
    chk("hw_full", 32'(buf_full), 32'h0);
    chk("hw_fwd_young", ld_data, 32'h5);
    chk("hw_head_data", mem_wdata, 32'h1);
    for (int c = 0; c < 8; c++) step(0, 0, 0, 1, 0, 32'h300, 0);
    chk("hw_drained", 32'(buf_empty), 32'h1);

    // flush does not disturb buffered stores or the pending pulse
    step(1, 32'h40, 32'h440, 0, 0, 32'h44, 0);
    step(0, 0, 0, 0, 0, 32'h44, 0);
    step(1, 32'h44, 32'h444, 0, 0, 32'h44, 0);
    chk("flush_pending_se", 32'(store_executed), 32'h1);
    step(0, 0, 0, 0, 1, 32'h44, 0);
    chk("flush_no_se", 32'(store_executed), 32'h0);
    chk("flush_kept", 32'(ld_hit), 32'h1);
    for (int c = 0; c < 10; c++) step(0, 0, 0, 1, 0, 32'h44, 0);
    chk("flush_drained", 32'(buf_empty), 32'h1);

    // reset in the middle of a write with three entries buffered
    step(1, 32'h80, 32'h1, 0, 0, 32'h80, 0);
    step(0, 0, 0, 0, 0, 32'h80, 0);
    step(1, 32'h84, 32'h2, 0, 0, 32'h80, 0);
    step(0, 0, 0, 0, 0, 32'h80, 0);
    step(1, 32'h88, 32'h3, 0, 0, 32'h80, 0);
    step(0, 0, 0, 0, 0, 32'h80, 0);
    chk("rst_pre_wr", 32'(mem_wr_en), 32'h1);
    step(1, 32'h8C, 32'h4, 1, 0, 32'h80, 1);
    chk("rst_wr", 32'(mem_wr_en), 32'h0);
    chk("rst_empty", 32'(buf_empty), 32'h1);
    chk("rst_hit", 32'(ld_hit), 32'h0);
    chk("rst_se", 32'(store_executed), 32'h0);
    step(0, 0, 0, 0, 0, 32'h80, 0);

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      ra = 32'($urandom_range(0, 7)) << 2;
      step($urandom_range(0, 9) < 6, ra, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0, 32'($urandom_range(0, 7)) << 2,
           $urandom_range(0, 99) == 0);
    end
    for (int c = 0; c < 12; c++) step(0, 0, 0, 1, 0, 0, 0);
    chk("final_empty", 32'(buf_empty), 32'h1);
    chk("sb_leftover", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
